// File: rtl/time_display_driver_pkg.sv
// Shared constants, state encoding and digit helpers for the stopwatch display driver.
package time_display_driver_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    localparam int MS_PER_MIN = 60000;
    localparam int MS_PER_SEC = 1000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIV_MIN,
        ST_DIV_SEC,
        ST_BCD,
        ST_LOAD
    } state_t;

    function automatic logic [6:0] seg_code(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // One double-dabble step on three BCD nibbles: add-3 correction, then shift in b.
    function automatic logic [11:0] dabble_step(input logic [11:0] bcd, input logic b);
        logic [11:0] adj;
        adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        return {adj[10:0], b};
    endfunction

endpackage

// File: rtl/time_display_driver_seq_divider.sv
// Restoring shift-subtract divider: loads on start, then N_W steps; done flags the final step,
// results are valid from the following cycle and hold until the next start.
module seq_divider #(
    parameter int N_W = 39,
    parameter int D_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N_W-1:0] n,
    input  logic [D_W-1:0] d,
    output logic [N_W-1:0] q,
    output logic [D_W-1:0] r,
    output logic           done
);
    localparam int CNT_W = $clog2(N_W + 1);

    logic [CNT_W-1:0] cnt;
    logic [D_W:0]     trial;

    assign trial = {r, q[N_W-1]};
    assign done  = (cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= '0;
            r   <= '0;
            cnt <= '0;
        end else if (start) begin
            q   <= n;
            r   <= '0;
            cnt <= CNT_W'(N_W);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
            if (trial >= {1'b0, d}) begin
                r <= D_W'(trial - {1'b0, d});
                q <= {q[N_W-2:0], 1'b1};
            end else begin
                r <= trial[D_W-1:0];
                q <= {q[N_W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/time_display_driver.sv
// Stopwatch ms -> MMM:SS.mmm on an 8-digit multiplexed 7-segment display, with blink on zero.
//  state       | meaning
//  ST_IDLE     | waiting for a refresh tick
//  ST_DIV_MIN  | t / 60000 -> minutes, remainder
//  ST_DIV_SEC  | start + remainder / 1000 -> seconds, ms
//  ST_BCD      | 10 double-dabble shifts (min, sec, ms in parallel)
//  ST_LOAD     | commit all digits at once
module time_display_driver #(
    parameter int T_W         = 39,
    parameter int REFRESH_DIV = 100_000,
    parameter int SCAN_DIV    = 100_000,
    parameter int BLINK_DIV   = 25_000_000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [T_W-1:0] t,
    input  logic           zero,
    output logic [7:0]     an,
    output logic [6:0]     seg,
    output logic           dp,
    output logic           busy
);
    import time_display_driver_pkg::*;

    localparam int REF_W  = $clog2(REFRESH_DIV + 1);
    localparam int SCAN_W = $clog2(SCAN_DIV + 1);
    localparam int BLK_W  = $clog2(BLINK_DIV + 1);

    state_t state, state_nxt;

    logic [REF_W-1:0]  ref_cnt;
    logic [SCAN_W-1:0] scan_cnt;
    logic [BLK_W-1:0]  blink_cnt;
    logic              tick, blink_on, frame_valid, sec_start, sat;
    logic [2:0]        digit_idx;
    logic [3:0]        bcd_cnt, digit;
    logic [T_W-1:0]    min_q;
    logic [15:0]       min_r, sec_q;
    logic [9:0]        sec_r, bin_min, bin_sec, bin_ms;
    logic              min_done, sec_done;
    logic [11:0]       bcd_min, bcd_sec, bcd_ms;
    logic [11:0]       disp_min, disp_ms;
    logic [7:0]        disp_sec;

    assign tick = (ref_cnt == '0);
    assign busy = (state != ST_IDLE);

    seq_divider #(.N_W(T_W), .D_W(16)) u_div_min (
        .clk(clk), .rst(rst), .start(state == ST_IDLE && tick),
        .n(t), .d(16'(MS_PER_MIN)), .q(min_q), .r(min_r), .done(min_done)
    );

    seq_divider #(.N_W(16), .D_W(10)) u_div_sec (
        .clk(clk), .rst(rst), .start(sec_start),
        .n(min_r), .d(10'(MS_PER_SEC)), .q(sec_q), .r(sec_r), .done(sec_done)
    );

    // Divider outputs stay stable through BCD, so the shift reads them bit by bit in place.
    assign sat     = (min_q > T_W'(999));
    assign bin_min = sat ? 10'd999 : 10'(min_q);
    assign bin_sec = sat ? 10'd59  : 10'(sec_q);
    assign bin_ms  = sat ? 10'd999 : sec_r;

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (tick)           state_nxt = ST_DIV_MIN;
            ST_DIV_MIN: if (min_done)       state_nxt = ST_DIV_SEC;
            ST_DIV_SEC: if (sec_done)       state_nxt = ST_BCD;
            ST_BCD:     if (bcd_cnt == '0)  state_nxt = ST_LOAD;
            ST_LOAD:                        state_nxt = ST_IDLE;
            default:                        state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            ref_cnt     <= REF_W'(REFRESH_DIV - 1);
            sec_start   <= 1'b0;
            bcd_cnt     <= '0;
            bcd_min     <= '0;
            bcd_sec     <= '0;
            bcd_ms      <= '0;
            disp_min    <= '0;
            disp_sec    <= '0;
            disp_ms     <= '0;
            frame_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            ref_cnt   <= tick ? REF_W'(REFRESH_DIV - 1) : ref_cnt - 1'b1;
            sec_start <= (state == ST_DIV_MIN) && min_done;
            if (state == ST_DIV_SEC && sec_done) begin
                bcd_min <= '0;
                bcd_sec <= '0;
                bcd_ms  <= '0;
                bcd_cnt <= 4'd9;
            end else if (state == ST_BCD) begin
                bcd_min <= dabble_step(bcd_min, bin_min[bcd_cnt]);
                bcd_sec <= dabble_step(bcd_sec, bin_sec[bcd_cnt]);
                bcd_ms  <= dabble_step(bcd_ms,  bin_ms[bcd_cnt]);
                bcd_cnt <= bcd_cnt - 1'b1;
            end
            if (state == ST_LOAD) begin
                disp_min    <= bcd_min;
                disp_sec    <= 8'(bcd_sec);
                disp_ms     <= bcd_ms;
                frame_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt  <= SCAN_W'(SCAN_DIV - 1);
            digit_idx <= '0;
            blink_cnt <= BLK_W'(BLINK_DIV - 1);
            blink_on  <= 1'b1;
        end else begin
            if (scan_cnt == '0) begin
                scan_cnt  <= SCAN_W'(SCAN_DIV - 1);
                digit_idx <= digit_idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt - 1'b1;
            end
            if (!zero) begin
                blink_on  <= 1'b1;
                blink_cnt <= BLK_W'(BLINK_DIV - 1);
            end else if (blink_cnt == '0) begin
                blink_on  <= ~blink_on;
                blink_cnt <= BLK_W'(BLINK_DIV - 1);
            end else begin
                blink_cnt <= blink_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        digit = DIGIT_BLANK;
        unique case (digit_idx)
            3'd7: digit = (disp_min[11:8] == 4'd0) ? DIGIT_BLANK : disp_min[11:8];
            3'd6: digit = (disp_min[11:4] == 8'd0) ? DIGIT_BLANK : disp_min[7:4];
            3'd5: digit = disp_min[3:0];
            3'd4: digit = disp_sec[7:4];
            3'd3: digit = disp_sec[3:0];
            3'd2: digit = disp_ms[11:8];
            3'd1: digit = disp_ms[7:4];
            3'd0: digit = disp_ms[3:0];
            default: digit = DIGIT_BLANK;
        endcase
    end

    // an, seg and dp all derive from the same registers, so they switch together.
    assign an  = (frame_valid && blink_on) ? ~(8'd1 << digit_idx) : 8'hFF;
    assign seg = (frame_valid && blink_on) ? seg_code(digit) : SEG_BLANK;
    assign dp  = !(frame_valid && blink_on && (digit_idx == 3'd5 || digit_idx == 3'd3));

endmodule

// File: tb/tb_time_display_driver.sv
// Scoreboard bench for time_display_driver: stimulus pushes hand-computed frames, a monitor
// reads each freshly loaded frame off the scanned display and compares.
module tb_time_display_driver;
    localparam int T_W         = 39;
    localparam int REFRESH_DIV = 64;
    localparam int SCAN_DIV    = 4;
    localparam int BLINK_DIV   = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [T_W-1:0] t = '0;
    logic           zero = 1'b0;
    logic [7:0]     an;
    logic [6:0]     seg;
    logic           dp, busy;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] sb_q[$];
    bit          mon_active = 0;

    time_display_driver #(
        .T_W(T_W), .REFRESH_DIV(REFRESH_DIV), .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk(clk), .rst(rst), .t(t), .zero(zero),
        .an(an), .seg(seg), .dp(dp), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] exp_seg(input logic [3:0] nib);
        case (nib)
            4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
            4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic wait_busy(input logic lvl, input string name);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (busy !== lvl && c < 400);
        if (busy !== lvl) check({"timeout_", name}, {63'd0, busy}, {63'd0, lvl});
    endtask

    task automatic wait_mon_idle();
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while ((sb_q.size() != 0 || mon_active) && c < 400);
        if (sb_q.size() != 0 || mon_active) check("timeout_monitor", 64'(sb_q.size()), 64'd0);
    endtask

    // Expected frame as 8 nibbles, digit7..digit0; nibble F = blank digit.
    task automatic apply(input logic [T_W-1:0] tv, input logic [31:0] exp_frame);
        wait_busy(1'b0, "idle");
        t = tv;
        wait_busy(1'b1, "start");
        sb_q.push_back(exp_frame);
        wait_busy(1'b0, "finish");
        wait_mon_idle();
    endtask

    initial begin : monitor
        logic        busy_prev;
        logic [31:0] exp_frame;
        logic [6:0]  seen[8];
        logic [7:0]  mask;
        logic [55:0] act, req;
        int          idx;
        bit          scan_err;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_prev && !busy && sb_q.size() > 0) begin
                mon_active = 1;
                exp_frame  = sb_q.pop_front();
                mask       = '0;
                scan_err   = 0;
                idx        = 0;
                for (int c = 0; c < 8 * SCAN_DIV; c++) begin
                    if ($countones(~an) != 1) begin
                        scan_err = 1;
                    end else begin
                        for (int i = 0; i < 8; i++) if (!an[i]) idx = i;
                        seen[idx] = seg;
                        mask[idx] = 1'b1;
                        if (dp !== ((idx == 5 || idx == 3) ? 1'b0 : 1'b1)) scan_err = 1;
                    end
                    @(negedge clk);
                end
                for (int i = 0; i < 8; i++) begin
                    act[7*i +: 7] = mask[i] ? seen[i] : 7'h7F;
                    req[7*i +: 7] = exp_seg(exp_frame[4*i +: 4]);
                end
                check($sformatf("frame_%08h", exp_frame), {mask, act}, {8'hFF, req});
                check("scan_onehot_dp", {63'd0, scan_err}, 64'd0);
                mon_active = 0;
            end
            busy_prev = busy;
        end
    end

    initial begin : stimulus
        int          cycles, a, b, cc, found;
        bit          ff_seq[120];
        logic [63:0] rnd;

        repeat (3) @(negedge clk);
        check("reset_an", {56'd0, an}, 64'hFF);
        check("reset_seg", {57'd0, seg}, 64'h7F);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_dp", {63'd0, dp}, 64'd1);
        rst = 1'b0;

        apply(39'd0,          32'hFF000000);
        apply(39'd83_456,     32'hFF123456);
        apply(39'd59_999_999, 32'h99959999);
        apply(39'd60_000_000, 32'h99959999);
        apply({T_W{1'b1}},    32'h99959999);
        apply(39'd754_321,    32'hF1234321);
        apply(39'd3_599_999,  32'hF5959999);
        apply(39'd6_000_000,  32'h10000000);
        apply(39'd59_999,     32'hFF059999);
        apply(39'd60_000,     32'hFF100000);

        // Input churns during the conversion; the frame must reflect the tick-time value.
        wait_busy(1'b0, "idle_churn");
        t = 39'd1_234_567;
        wait_busy(1'b1, "start_churn");
        sb_q.push_back(32'hF2034567);
        cycles = 1;
        for (int c = 0; c < 200; c++) begin
            rnd = {$urandom(), $urandom()};
            t   = rnd[T_W-1:0];
            @(negedge clk);
            if (busy) cycles++;
            else break;
        end
        t = 39'd1_234_567;
        check("busy_len", 64'(cycles), 64'(T_W + 28));
        wait_mon_idle();

        zero = 1'b1;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            ff_seq[c] = (an == 8'hFF);
        end
        a = -1; b = -1; cc = -1;
        for (int c = 1; c < 120; c++) begin
            if (!ff_seq[c-1] && ff_seq[c]) begin
                if (a < 0) a = c;
                else if (b >= 0 && cc < 0) cc = c;
            end
            if (ff_seq[c-1] && !ff_seq[c] && a >= 0 && b < 0) b = c;
        end
        check("blink_off_len", 64'(b - a), 64'd16);
        check("blink_on_len", 64'(cc - b), 64'd16);

        found = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (an != 8'hFF) break;
        end
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (an == 8'hFF) begin
                found = 1;
                break;
            end
        end
        check("blink_off_seen", 64'(found), 64'd1);
        repeat (3) @(negedge clk);
        zero = 1'b0;
        @(negedge clk);
        check("zero_drop_resume", {63'd0, an == 8'hFF}, 64'd0);

        // Abort mid DIV_SEC, then confirm a clean conversion afterwards.
        wait_mon_idle();
        wait_busy(1'b0, "idle_abort");
        t = 39'd3_599_999;
        wait_busy(1'b1, "start_abort");
        repeat (T_W + 5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_an", {56'd0, an}, 64'hFF);
        check("abort_seg", {57'd0, seg}, 64'h7F);
        rst = 1'b0;
        wait_busy(1'b1, "start_after_abort");
        sb_q.push_back(32'hF5959999);
        wait_busy(1'b0, "finish_after_abort");
        wait_mon_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
